// File: rtl/pipe_hazard_ctrl.sv
// Central hazard/flow controller: pipeline stall and bubble control, PC redirect
// for jumps, traps and mret, flush-window sequencing and a stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ifetch_ready,
  input  logic                 mem_busy,
  input  logic                 load_use_id,
  input  logic                 jump_ex,
  input  logic [31:0]          jump_addr_ex,
  input  logic                 trap_req,
  input  logic [31:0]          trap_vector,
  input  logic                 mret_req,
  input  logic [31:0]          mepc,
  output logic                 stall_n,
  output logic                 hold_flag,
  output logic                 flush_id_ex,
  output logic                 pc_load,
  output logic [31:0]          pc_load_addr,
  output logic                 trap_ack,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  localparam int unsigned FCW = 2;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [FCW-1:0]       flush_cnt_q, flush_cnt_d;
  logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
  logic                 redirect;

  // Next state and zero-latency control outputs
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    redirect     = 1'b0;
    stall_n      = 1'b1;
    hold_flag    = 1'b0;
    flush_id_ex  = 1'b0;
    pc_load      = 1'b0;
    pc_load_addr = 32'h0;
    trap_ack     = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_busy) begin
          stall_n = 1'b0;
        end else if (trap_req) begin
          redirect     = 1'b1;
          trap_ack     = 1'b1;
          pc_load_addr = trap_vector;
        end else if (mret_req) begin
          redirect     = 1'b1;
          trap_ack     = 1'b1;
          pc_load_addr = mepc;
        end else if (jump_ex) begin
          redirect     = 1'b1;
          pc_load_addr = jump_addr_ex;
        end else if (load_use_id) begin
          stall_n     = 1'b0;
          flush_id_ex = 1'b1;
        end else if (!ifetch_ready) begin
          stall_n = 1'b0;
        end

        if (redirect) begin
          pc_load     = 1'b1;
          hold_flag   = 1'b1;
          flush_id_ex = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d     = FLUSH;
            flush_cnt_d = FCW'(FLUSH_CYCLES - 1);
          end
        end
      end

      FLUSH: begin
        // EX holds bubbles; a busy data bus freezes the window
        hold_flag   = 1'b1;
        flush_id_ex = 1'b1;
        stall_n     = ifetch_ready & ~mem_busy;
        if (!mem_busy) begin
          flush_cnt_d = flush_cnt_q - FCW'(1);
          if (flush_cnt_q == FCW'(1)) begin
            state_d = RUN;
          end
        end
      end

      default: begin
        state_d     = RUN;
        flush_cnt_d = '0;
      end
    endcase

    if (!rst_n) begin
      stall_n      = 1'b0;
      hold_flag    = 1'b1;
      flush_id_ex  = 1'b1;
      pc_load      = 1'b0;
      pc_load_addr = 32'h0;
      trap_ack     = 1'b0;
    end

    stall_cycles_d = stall_cycles_q;
    if (!stall_n && (stall_cycles_q != {CNT_WIDTH{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      flush_cnt_q    <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

  a_load_runs: assert property (@(posedge clk) disable iff (!rst_n) pc_load |-> stall_n);
  a_ack_load:  assert property (@(posedge clk) disable iff (!rst_n) trap_ack |-> pc_load);
  a_flush_hold: assert property (@(posedge clk) disable iff (!rst_n)
                                 (state_q == FLUSH) |-> hold_flag);

endmodule
